// File: rtl/i2c_slave_pkg.sv
// Shared types for the I2C register-file target: FSM states, ACK levels, default address
// and the majority vote used by the optional glitch filter.
package i2c_slave_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_IGNORE
  } i2c_state_t;

  localparam logic       ACK              = 1'b0;
  localparam logic       NACK             = 1'b1;
  localparam logic [6:0] DEFAULT_SLV_ADDR = 7'h48;

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/i2c_sync_filter.sv
// Two-flop synchroniser with edge outputs; I2C_GLITCH_FILTER_EN adds a 3-tap majority
// filter that rejects single-clock spikes at the cost of two clocks of latency.
module i2c_sync_filter
  import i2c_slave_pkg::*;
#(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [1:0] sync_reg;
  logic       filt;
  logic       prev_reg;

  always_ff @(posedge clk) begin
    if (rst) sync_reg <= {2{RST_VAL}};
    else     sync_reg <= {sync_reg[0], async_in};
  end

`ifdef I2C_GLITCH_FILTER_EN
  logic [2:0] tap_reg;

  always_ff @(posedge clk) begin
    if (rst) tap_reg <= {3{RST_VAL}};
    else     tap_reg <= {tap_reg[1:0], sync_reg[1]};
  end

  assign filt = maj3(tap_reg);
`else
  assign filt = sync_reg[1];
`endif

  always_ff @(posedge clk) begin
    if (rst) prev_reg <= RST_VAL;
    else     prev_reg <= filt;
  end

  assign level = filt;
  assign rise  = filt & ~prev_reg;
  assign fall  = ~filt & prev_reg;

endmodule

// File: rtl/i2c_slave_regfile.sv
// Oversampled I2C target exposing an NREGS x 8 register file with auto-increment pointer;
// reg 0 is a read-only heartbeat counter. Optional SCL/SDA glitch filter: I2C_GLITCH_FILTER_EN.
module i2c_slave_regfile
  import i2c_slave_pkg::*;
#(
  parameter logic [6:0] SLV_ADDR = DEFAULT_SLV_ADDR,
  parameter int         NREGS    = 8,
  parameter int         CNT_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               scl_in,
  input  logic               sda_in,
  output logic               sda_oe,
  input  logic               batimento,
  output logic [NREGS*8-1:0] regs_out,
  output logic               wr_strobe
);

  localparam int PW = $clog2(NREGS);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;
  logic bat_lvl, bat_rise, bat_fall;

  i2c_sync_filter #(.RST_VAL(1'b1)) u_scl (
    .clk(clk), .rst(rst), .async_in(scl_in),
    .level(scl_lvl), .rise(scl_rise), .fall(scl_fall)
  );
  i2c_sync_filter #(.RST_VAL(1'b1)) u_sda (
    .clk(clk), .rst(rst), .async_in(sda_in),
    .level(sda_lvl), .rise(sda_rise), .fall(sda_fall)
  );
  i2c_sync_filter #(.RST_VAL(1'b0)) u_bat (
    .clk(clk), .rst(rst), .async_in(batimento),
    .level(bat_lvl), .rise(bat_rise), .fall(bat_fall)
  );

  i2c_state_t       state_reg;
  logic [3:0]       bit_cnt_reg;
  logic [7:0]       shift_reg;
  logic [7:0]       tx_reg;
  logic [PW-1:0]    ptr_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             sda_oe_reg;
  logic             wr_strobe_reg;
  logic             rw_reg;
  logic             mack_reg;
  logic [7:0]       regs_reg [NREGS];

  logic          start_det, stop_det;
  logic [7:0]    rx_full, rd_byte, cnt_byte;
  logic [PW-1:0] ptr_inc;

  assign start_det = sda_fall & scl_lvl;
  assign stop_det  = sda_rise & scl_lvl;
  assign rx_full   = {shift_reg[6:0], sda_lvl};
  assign cnt_byte  = 8'(cnt_reg);
  assign ptr_inc   = (ptr_reg == PW'(NREGS - 1)) ? '0 : ptr_reg + PW'(1);
  // Reg 0 always reads the live counter; the byte is captured into tx_reg at load time.
  assign rd_byte   = (ptr_reg == '0) ? cnt_byte : regs_reg[ptr_reg];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      bit_cnt_reg   <= '0;
      shift_reg     <= '0;
      tx_reg        <= '0;
      ptr_reg       <= '0;
      cnt_reg       <= '0;
      sda_oe_reg    <= 1'b0;
      wr_strobe_reg <= 1'b0;
      rw_reg        <= 1'b0;
      mack_reg      <= NACK;
      for (int i = 0; i < NREGS; i++) regs_reg[i] <= '0;
    end else begin
      wr_strobe_reg <= 1'b0;
      if (bat_rise) cnt_reg <= cnt_reg + CNT_W'(1);

      if (start_det) begin
        state_reg   <= ST_ADDR;
        bit_cnt_reg <= '0;
        sda_oe_reg  <= 1'b0;
      end else if (stop_det) begin
        state_reg  <= ST_IDLE;
        sda_oe_reg <= 1'b0;
      end else begin
        case (state_reg)
          ST_ADDR, ST_PTR, ST_WDATA: begin
            if (scl_rise && bit_cnt_reg != 4'd8) begin
              shift_reg   <= rx_full;
              bit_cnt_reg <= bit_cnt_reg + 4'd1;
              if (state_reg == ST_WDATA && bit_cnt_reg == 4'd7) begin
                if (ptr_reg != '0) begin
                  regs_reg[ptr_reg] <= rx_full;
                  wr_strobe_reg     <= 1'b1;
                end
                ptr_reg <= ptr_inc;
              end
            end else if (scl_fall && bit_cnt_reg == 4'd8) begin
              // Byte complete: decide ACK on the fall so SDA moves only while SCL is low.
              bit_cnt_reg <= '0;
              case (state_reg)
                ST_ADDR: begin
                  if (shift_reg[7:1] == SLV_ADDR) begin
                    rw_reg     <= shift_reg[0];
                    sda_oe_reg <= 1'b1;
                    state_reg  <= ST_ADDR_ACK;
                  end else begin
                    state_reg <= ST_IGNORE;
                  end
                end
                ST_PTR: begin
                  if ({24'd0, shift_reg} < NREGS) begin
                    ptr_reg    <= shift_reg[PW-1:0];
                    sda_oe_reg <= 1'b1;
                    state_reg  <= ST_PTR_ACK;
                  end else begin
                    state_reg <= ST_IGNORE;
                  end
                end
                default: begin
                  sda_oe_reg <= 1'b1;
                  state_reg  <= ST_WDATA_ACK;
                end
              endcase
            end
          end
          ST_ADDR_ACK: begin
            if (scl_fall) begin
              if (rw_reg) begin
                tx_reg     <= rd_byte;
                sda_oe_reg <= ~rd_byte[7];
                state_reg  <= ST_RDATA;
              end else begin
                sda_oe_reg <= 1'b0;
                state_reg  <= ST_PTR;
              end
            end
          end
          ST_PTR_ACK, ST_WDATA_ACK: begin
            if (scl_fall) begin
              sda_oe_reg <= 1'b0;
              state_reg  <= ST_WDATA;
            end
          end
          ST_RDATA: begin
            if (scl_rise && bit_cnt_reg != 4'd8) begin
              bit_cnt_reg <= bit_cnt_reg + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt_reg == 4'd8) begin
                sda_oe_reg  <= 1'b0;
                bit_cnt_reg <= '0;
                state_reg   <= ST_RDATA_ACK;
              end else begin
                tx_reg     <= {tx_reg[6:0], 1'b0};
                sda_oe_reg <= ~tx_reg[6];
              end
            end
          end
          ST_RDATA_ACK: begin
            if (scl_rise) begin
              mack_reg <= sda_lvl;
              if (sda_lvl == ACK) ptr_reg <= ptr_inc;
            end else if (scl_fall) begin
              if (mack_reg == ACK) begin
                tx_reg     <= rd_byte;
                sda_oe_reg <= ~rd_byte[7];
                state_reg  <= ST_RDATA;
              end else begin
                state_reg <= ST_IGNORE;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign sda_oe    = sda_oe_reg;
  assign wr_strobe = wr_strobe_reg;
  assign regs_out[7:0] = cnt_byte;

  for (genvar gi = 1; gi < NREGS; gi++) begin : g_regs
    assign regs_out[8*gi +: 8] = regs_reg[gi];
  end

endmodule
